// File: rtl/bip_pkg.sv
// -----------------------------------------------------------------------------
// bip_pkg
// Shared definitions for the BIP1 processor.
//   - Opcode encodings used by instruction_decoder and bip_run_controller.
//   - State encoding of the run/halt controller.
// No ports (package).
// -----------------------------------------------------------------------------
package bip_pkg;

   localparam logic [4:0] OP_HLT  = 5'b00000;
   localparam logic [4:0] OP_STO  = 5'b00001;
   localparam logic [4:0] OP_LD   = 5'b00010;
   localparam logic [4:0] OP_LDI  = 5'b00011;
   localparam logic [4:0] OP_ADD  = 5'b00100;
   localparam logic [4:0] OP_ADDI = 5'b00101;
   localparam logic [4:0] OP_SUB  = 5'b00110;
   localparam logic [4:0] OP_SUBI = 5'b00111;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_RUN   = 3'd2,
      ST_SEND  = 3'd3,
      ST_WAIT  = 3'd4
   } run_state_t;

endpackage

// File: rtl/bip_frame_mux.sv
// -----------------------------------------------------------------------------
// bip_frame_mux
// Combinational byte selector for the result frame. The frame is the
// instruction count (MSB byte first) followed by the accumulator snapshot
// (MSB byte first).
// Ports:
//   byte_idx   in   frame byte position (0 = cycle-count MSB)
//   cycles     in   executed-instruction count
//   snapshot   in   accumulator captured at HLT
//   frame_byte out  selected byte (zero for out-of-range positions)
// -----------------------------------------------------------------------------
module bip_frame_mux #(
   parameter int NB_DATA   = 16,
   parameter int NB_CYCLES = 16,
   parameter int NB_BYTE   = 8,
   parameter int NB_IDX    = 2
) (
   input  logic [NB_IDX-1:0]    byte_idx,
   input  logic [NB_CYCLES-1:0] cycles,
   input  logic [NB_DATA-1:0]   snapshot,
   output logic [NB_BYTE-1:0]   frame_byte
);

   localparam int CYC_BYTES = NB_CYCLES / NB_BYTE;
   localparam int DAT_BYTES = NB_DATA / NB_BYTE;

   always_comb begin
      frame_byte = '0;
      for (int k = 0; k < CYC_BYTES; k++) begin
         if (int'(byte_idx) == k)
            frame_byte = cycles[NB_CYCLES-1-NB_BYTE*k -: NB_BYTE];
      end
      for (int k = 0; k < DAT_BYTES; k++) begin
         if (int'(byte_idx) == CYC_BYTES + k)
            frame_byte = snapshot[NB_DATA-1-NB_BYTE*k -: NB_BYTE];
      end
   end

endmodule

// File: rtl/bip_run_controller.sv
// -----------------------------------------------------------------------------
// bip_run_controller
// Run/halt sequencer for the BIP1 processor. A start command clears the PC and
// lets the datapath execute one instruction per clock until HLT is addressed;
// the datapath is then frozen and a result frame (instruction count, then the
// accumulator snapshot, each MSB byte first) is streamed to the UART TX.
//
// Optional feature: define RUN_CTRL_STEP_EN to add the i_step input; in RUN a
// non-HLT instruction then executes only in cycles where i_step is high.
//
// Ports:
//   i_clk       in   system clock (rising edge)
//   i_rst       in   synchronous active-low reset
//   i_start     in   one-cycle run command, honoured only in IDLE
//   i_step      in   single-step enable (RUN_CTRL_STEP_EN builds only)
//   i_opcode    in   opcode currently addressed by the PC
//   i_acc       in   accumulator value
//   i_tx_done   in   one-cycle pulse: UART byte transmitted
//   o_cpu_en    out  datapath write-enable gate (combinational)
//   o_pc_clr    out  synchronous PC clear
//   o_halted    out  result frame fully sent, held until next start
//   o_cycles    out  executed-instruction count (saturating)
//   o_tx_start  out  one-cycle UART TX request
//   o_tx_data   out  byte to transmit, valid with o_tx_start
// -----------------------------------------------------------------------------
module bip_run_controller
   import bip_pkg::*;
#(
   parameter int NB_OPCODE = 5,
   parameter int NB_DATA   = 16,
   parameter int NB_CYCLES = 16,
   parameter int NB_BYTE   = 8
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_start,
`ifdef RUN_CTRL_STEP_EN
   input  logic                 i_step,
`endif
   input  logic [NB_OPCODE-1:0] i_opcode,
   input  logic [NB_DATA-1:0]   i_acc,
   input  logic                 i_tx_done,
   output logic                 o_cpu_en,
   output logic                 o_pc_clr,
   output logic                 o_halted,
   output logic [NB_CYCLES-1:0] o_cycles,
   output logic                 o_tx_start,
   output logic [NB_BYTE-1:0]   o_tx_data
);

   localparam int FRAME_BYTES = (NB_CYCLES / NB_BYTE) + (NB_DATA / NB_BYTE);
   localparam int NB_IDX      = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
   localparam logic [NB_IDX-1:0]    LAST_IDX = NB_IDX'(FRAME_BYTES - 1);
   localparam logic [NB_OPCODE-1:0] HLT      = NB_OPCODE'(OP_HLT);

   run_state_t          state;
   logic [NB_IDX-1:0]   byte_idx;
   logic [NB_IDX-1:0]   mux_idx;
   logic [NB_DATA-1:0]  snapshot;
   logic [NB_BYTE-1:0]  frame_byte;
   logic                is_hlt;
   logic                step_ok;

`ifdef RUN_CTRL_STEP_EN
   assign step_ok = i_step;
`else
   assign step_ok = 1'b1;
`endif

   assign is_hlt   = (i_opcode == HLT);
   // The opcode comes from the same-cycle program-memory read, so the enable
   // cannot wait for a register stage.
   assign o_cpu_en = (state == ST_RUN) && !is_hlt && step_ok;

   // o_tx_data is registered on entry to SEND, so the mux looks at the byte
   // that SEND is about to present: byte 0 when leaving RUN, the following
   // byte when leaving WAIT. Byte 0 always comes from the cycle count, so the
   // snapshot being captured on that same edge is never needed yet.
   assign mux_idx = (state == ST_WAIT) ? byte_idx + 1'b1 : '0;

   bip_frame_mux #(
      .NB_DATA   (NB_DATA),
      .NB_CYCLES (NB_CYCLES),
      .NB_BYTE   (NB_BYTE),
      .NB_IDX    (NB_IDX)
   ) u_frame_mux (
      .byte_idx   (mux_idx),
      .cycles     (o_cycles),
      .snapshot   (snapshot),
      .frame_byte (frame_byte)
   );

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state      <= ST_IDLE;
         byte_idx   <= '0;
         snapshot   <= '0;
         o_pc_clr   <= 1'b0;
         o_halted   <= 1'b0;
         o_cycles   <= '0;
         o_tx_start <= 1'b0;
         o_tx_data  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (i_start) begin
                  state    <= ST_CLEAR;
                  o_halted <= 1'b0;
                  o_pc_clr <= 1'b1;
               end
            end
            ST_CLEAR: begin
               o_pc_clr <= 1'b0;
               o_cycles <= '0;
               byte_idx <= '0;
               state    <= ST_RUN;
            end
            ST_RUN: begin
               if (is_hlt) begin
                  snapshot   <= i_acc;
                  o_tx_start <= 1'b1;
                  o_tx_data  <= frame_byte;
                  state      <= ST_SEND;
               end else if (step_ok && (o_cycles != '1)) begin
                  o_cycles <= o_cycles + 1'b1;
               end
            end
            ST_SEND: begin
               o_tx_start <= 1'b0;
               state      <= ST_WAIT;
            end
            ST_WAIT: begin
               if (i_tx_done) begin
                  if (byte_idx == LAST_IDX) begin
                     o_halted <= 1'b1;
                     state    <= ST_IDLE;
                  end else begin
                     byte_idx   <= byte_idx + 1'b1;
                     o_tx_start <= 1'b1;
                     o_tx_data  <= frame_byte;
                     state      <= ST_SEND;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/bip_run_controller.md
# bip_run_controller

Run/halt sequencer for the BIP1 processor. On a start command it clears the PC and lets the datapath execute one instruction per clock until the decoder sees HLT. It then freezes the datapath and streams a result frame (executed-instruction count, then the accumulator) to the UART transmitter through a byte handshake. It sits between the UART RX/TX interface and the CPU core, and gates every datapath write enable produced by instruction_decoder.

## Interface
Parameters:
- NB_OPCODE, 5, opcode width; must match instruction_decoder.
- NB_DATA, 16, accumulator width; must be a multiple of 8.
- NB_CYCLES, 16, instruction-counter width; must be a multiple of 8.
- NB_BYTE, 8, UART byte width.

Ports:
- i_clk  in  1  single system clock; everything updates on the rising edge.
- i_rst  in  1  synchronous, active-low reset.
- i_start  in  1  one-cycle run command from UART RX; honoured only in IDLE.
- i_opcode  in  NB_OPCODE  opcode of the instruction currently addressed by the PC.
- i_acc  in  NB_DATA  current accumulator value.
- i_tx_done  in  1  one-cycle pulse from UART TX: byte transmitted.
- o_cpu_en  out  1  datapath enable; ANDed with WrPC, WrAcc and WrRam.
- o_pc_clr  out  1  synchronous PC clear.
- o_halted  out  1  result frame fully sent; held until the next start.
- o_cycles  out  NB_CYCLES  running count of executed instructions.
- o_tx_start  out  1  one-cycle request to UART TX.
- o_tx_data  out  NB_BYTE  byte to transmit; valid while o_tx_start is high.

## Operation
- State machine: IDLE, CLEAR, RUN, SEND, WAIT.
- IDLE:
  - o_cpu_en=0.
  - i_start=1 → CLEAR and o_halted clears.
- CLEAR (one cycle):
  - o_pc_clr=1, o_cycles←0, byte index←0.
  - Always → RUN.
- RUN, i_opcode ≠ HLT (5'b00000):
  - o_cpu_en=1.
  - o_cycles increments by one and saturates at all-ones.
- RUN, i_opcode = HLT:
  - o_cpu_en=0.
  - Accumulator snapshot ← i_acc.
  - → SEND.
- SEND:
  - o_tx_start=1 for one cycle, with o_tx_data = the current frame byte.
  - → WAIT.
- WAIT:
  - On i_tx_done, if this was the last byte: o_halted←1 and → IDLE.
  - Otherwise: byte index+1 and → SEND.
  - Without i_tx_done, stay in WAIT indefinitely.
- Frame: NB_CYCLES/8 bytes of o_cycles, MSB first, then NB_DATA/8 bytes of the snapshot, MSB first. Default frame is 4 bytes.
- HLT counts as zero executed instructions.
- i_start outside IDLE is ignored.
- i_tx_done outside WAIT is ignored.
- i_start and i_tx_done in the same cycle: each is evaluated only in its own state, so there is no conflict.

## Timing
- Reset: state=IDLE; o_cpu_en, o_pc_clr, o_halted, o_tx_start = 0; o_cycles=0; o_tx_data=0; byte index and snapshot = 0.
- Reset asserted mid-run or mid-frame aborts immediately. No partial frame is resumed.
- Registered outputs: o_pc_clr, o_halted, o_cycles, o_tx_start, o_tx_data.
- o_cpu_en is combinational from state and i_opcode, because the opcode comes from the same-cycle program-memory read.
- Latencies:
  - i_start at edge t → o_pc_clr high in cycle t+1 → first o_cpu_en in cycle t+2.
  - HLT seen in cycle h → first o_tx_start in cycle h+1.
  - Last i_tx_done at edge d → o_halted high from cycle d+1.
- The minimum gap between consecutive o_tx_start pulses is two cycles (done → SEND → pulse).

## Configuration
- RUN_CTRL_STEP_EN defined:
  - Adds input i_step (1 bit).
  - In RUN, a non-HLT instruction executes (o_cpu_en=1 and o_cycles+1) only in cycles where i_step=1. Otherwise the controller stays in RUN with o_cpu_en=0.
  - HLT is still detected without a step.
- RUN_CTRL_STEP_EN undefined: there is no i_step port and the controller free-runs as described above.

## Structure
- Shared package bip_pkg holds:
  - Opcode localparams: HLT 00000, STO 00001, LD 00010, LDI 00011, ADD 00100, ADDI 00101, SUB 00110, SUBI 00111.
  - The state encoding for this controller.
- One sub-module, bip_frame_mux: combinational byte selector mapping the byte index to the cycle-count or snapshot byte.

## Test plan
- Reset held low for 3 cycles during RUN → all outputs 0 and state IDLE on the next cycle.
- Program LDI 5; ADDI 3; HLT, then i_start, with i_tx_done returned 4 cycles after each o_tx_start:
  - Bytes 0x00, 0x02, 0x00, 0x08 in that order.
  - o_halted=1; o_cycles=2.
- Program starting with HLT → o_cpu_en never asserted; frame 0x00 0x00 then the accumulator bytes.
- i_start pulsed during RUN and during WAIT → no effect, and the frame is unchanged.
- Step mode (RUN_CTRL_STEP_EN) with a 3-instruction program and i_step pulsed every 5 cycles → o_cycles increments exactly once per pulse.
- Program looping forever with NB_CYCLES=8 → o_cycles saturates at 0xFF and o_cpu_en stays high.
